serial_shift_transmitter: RTL
=============================

SERIAL_SHIFT_TRANSMITTER -- requirements
Module: serial_shift_transmitter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, word length in bits; CLK_DIV, default 4, clk cycles per sclk half-period.
REQ-002 Port clk, input, 1: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port data_in, input, WIDTH: parallel word to transmit.
REQ-005 Port valid, input, 1: data_in holds a word to send.
REQ-006 Port ready, output, 1: block is idle and accepts a word.
REQ-007 Port sclk, output, 1: generated serial clock.
REQ-008 Port sdata, output, 1: serial data, LSB first.
REQ-009 Port latch, output, 1: end-of-frame strobe (see Configuration).
REQ-010 Port done, output, 1: one-cycle pulse at frame end.

Function
REQ-011 Acceptance SHALL occur on a clk edge where valid=1 and ready=1; data_in SHALL be captured into an internal shift word on that edge, and later data_in changes SHALL NOT affect the frame.
REQ-012 valid while ready=0 SHALL be ignored, with no queuing.
REQ-013 FSM states SHALL be IDLE, SETUP, HIGH, LATCH, DONE; ready=1 only in IDLE.
REQ-014 IDLE->SETUP SHALL occur on acceptance; the bit counter SHALL be cleared and sdata SHALL be driven with bit 0 of the captured word.
REQ-015 SETUP SHALL hold sclk=0 for exactly CLK_DIV cycles with sdata stable, then go to HIGH.
REQ-016 HIGH SHALL hold sclk=1 for exactly CLK_DIV cycles with sdata unchanged.
REQ-017 HIGH SHALL exit to SETUP with the next bit (shift word right by one) if bits remain; otherwise to LATCH if enabled, else to DONE.
REQ-018 sdata SHALL change only in the cycle sclk falls or on frame start, never while sclk=1.
REQ-019 Bit order SHALL be bit 0 first and bit WIDTH-1 last, so that a right-shifting receiver ends holding the original word.
REQ-020 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL count 0..WIDTH-1 with no wrap.
REQ-021 The divider counter SHALL be $clog2(CLK_DIV) bits wide; it SHALL reload to 0 on every state change.
REQ-022 DONE SHALL last exactly one cycle with done=1 and sclk=0, then go to IDLE; ready SHALL be 1 in the following cycle.
REQ-023 Without latch, ready SHALL be low for exactly 2*CLK_DIV*WIDTH+1 cycles per frame.
REQ-024 valid=1 arriving in the same cycle ready returns high SHALL start a new frame back-to-back.
REQ-025 Elaboration SHALL fail if WIDTH<2 or CLK_DIV<2.

Reset
REQ-026 When reset=0, the block SHALL asynchronously force state=IDLE, sclk=0, sdata=0, latch=0, done=0, ready=1, and clear both counters and the shift word.
REQ-027 Reset mid-frame SHALL abort the frame without emitting done or latch; the first cycle after release SHALL accept a new word.

Configuration
REQ-028 Macro SERIAL_TX_LATCH_EN defined: after the last HIGH, LATCH SHALL drive latch=1, sclk=0 for CLK_DIV cycles, then go to DONE; the frame becomes 2*CLK_DIV*WIDTH+CLK_DIV+1 cycles.
REQ-029 Macro not defined: the LATCH state and its logic SHALL be absent and latch SHALL be tied to 0; the port SHALL remain.

Structure
REQ-030 Package serial_tx_pkg SHALL hold the state enum typedef and the default WIDTH/CLK_DIV localparams.
REQ-031 One sub-module, serial_tx_tick_gen, SHALL produce the half-period tick from CLK_DIV with a synchronous restart input.

Verification
REQ-032 The bench SHALL cover: WIDTH=8, CLK_DIV=2, send 0xA5 -> sdata at the 8 sclk rising edges = 1,0,1,0,0,1,0,1, then done pulse.
REQ-033 The bench SHALL cover: same config, no macro -> ready low exactly 33 cycles; one done pulse; latch always 0.
REQ-034 The bench SHALL cover: SERIAL_TX_LATCH_EN, WIDTH=8, CLK_DIV=2 -> latch high 2 cycles after the 8th sclk high; ready low 35 cycles.
REQ-035 The bench SHALL cover: WIDTH=32, loopback into a right-shifting sclk-edge receiver, send 0xDEADBEEF then 0x00000001 back-to-back -> receiver holds each word after its frame.
REQ-036 The bench SHALL cover: valid pulsed with 0xFF mid-frame -> ignored, transmitted word unchanged.
REQ-037 The bench SHALL cover: reset=0 during bit 3 -> sclk=0, sdata=0, ready=1 immediately, no done; next word sent correctly.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial shift transmitter.
// The LATCH state exists only when SERIAL_TX_LATCH_EN is defined.
package serial_tx_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
`ifdef SERIAL_TX_LATCH_EN
    LATCH,
`endif
    DONE
  } tx_state_e;

endpackage

// File: rtl/serial_tx_tick_gen.sv
// Half-period tick generator: tick is high on the last of every CLK_DIV cycles.
// restart synchronously reloads the count so each FSM state starts a fresh period.
module serial_tx_tick_gen
  import serial_tx_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_shift_transmitter.sv
// Parallel-to-serial transmitter, LSB first, with generated sclk.
// Define SERIAL_TX_LATCH_EN to add a CLK_DIV-cycle latch strobe before done.
module serial_shift_transmitter
  import serial_tx_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             done
);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_shift_transmitter: WIDTH must be at least 2");
  end
  if (CLK_DIV < 2) begin : g_div_check
    $error("serial_shift_transmitter: CLK_DIV must be at least 2");
  end

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  tx_state_e        state;
  tx_state_e        next_state;
  logic [WIDTH-1:0] shift_word;
  logic [BIT_W-1:0] bit_cnt;
  logic             tick;
  logic             restart;
  logic             accept;
  logic             last_bit;

  assign accept   = (state == IDLE) && valid;
  assign last_bit = (bit_cnt == LAST_BIT);
  assign restart  = (next_state != state);
  assign sdata    = shift_word[0];

  serial_tx_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = SETUP;
      SETUP: if (tick) next_state = HIGH;
      HIGH: begin
        if (tick) begin
          if (!last_bit) begin
            next_state = SETUP;
          end else begin
`ifdef SERIAL_TX_LATCH_EN
            next_state = LATCH;
`else
            next_state = DONE;
`endif
          end
        end
      end
`ifdef SERIAL_TX_LATCH_EN
      LATCH: if (tick) next_state = DONE;
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they align with state and never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ready <= 1'b1;
      sclk  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      ready <= (next_state == IDLE);
      sclk  <= (next_state == HIGH);
      done  <= (next_state == DONE);
    end
  end

`ifdef SERIAL_TX_LATCH_EN
  logic latch_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_q <= 1'b0;
    end else begin
      latch_q <= (next_state == LATCH);
    end
  end

  assign latch = latch_q;
`else
  assign latch = 1'b0;
`endif

  // The word shifts only when another bit follows, so sdata moves as sclk falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_word <= '0;
      bit_cnt    <= '0;
    end else if (accept) begin
      shift_word <= data_in;
      bit_cnt    <= '0;
    end else if (state == HIGH && tick && !last_bit) begin
      shift_word <= {1'b0, shift_word[WIDTH-1:1]};
      bit_cnt    <= bit_cnt + BIT_W'(1);
    end
  end

endmodule
